// File: rtl/trap_controller_if.sv
// rtl/trap_controller_if.sv - trap request and CSR trap-port bundle for trap_controller
//
// Signals:
//   trap_valid/trap_kind/trap_pc/trap_tval   request from the EX-stage exception detector
//   csr_ready/csr_trap_read_data             CSR file responses
//   csr_trap_read_address                    CSR read address (combinational read)
//   csr_trap_write/_address/_data            CSR trap-port write
//   trap_redirect/trap_target                one-cycle PC redirect
//   trap_done                                0 while a trap sequence is in progress
// Modports: master = trap_controller, slave = pipeline / CSR file side.
interface trap_controller_if #(
    parameter int XLEN = 32
);
    logic            trap_valid;
    logic [2:0]      trap_kind;
    logic [XLEN-1:0] trap_pc;
    logic [XLEN-1:0] trap_tval;
    logic            csr_ready;
    logic [XLEN-1:0] csr_trap_read_data;
    logic [11:0]     csr_trap_read_address;
    logic            csr_trap_write;
    logic [11:0]     csr_trap_write_address;
    logic [XLEN-1:0] csr_trap_write_data;
    logic            trap_redirect;
    logic [XLEN-1:0] trap_target;
    logic            trap_done;

    modport master (
        input  trap_valid, trap_kind, trap_pc, trap_tval, csr_ready, csr_trap_read_data,
        output csr_trap_read_address, csr_trap_write, csr_trap_write_address,
               csr_trap_write_data, trap_redirect, trap_target, trap_done
    );

    modport slave (
        output trap_valid, trap_kind, trap_pc, trap_tval, csr_ready, csr_trap_read_data,
        input  csr_trap_read_address, csr_trap_write, csr_trap_write_address,
               csr_trap_write_data, trap_redirect, trap_target, trap_done
    );
endinterface

// File: rtl/trap_controller.sv
// rtl/trap_controller.sv - pre-trap / trap-return CSR sequencer driving PC stall and redirect
//
// Ports:
//   clk      core clock
//   reset_n  asynchronous active-low reset
//   bus      trap_controller_if.master (trap request, CSR trap port, redirect, trap_done)
// Parameters:
//   XLEN            datapath / CSR width
//   EBREAK_TVAL_PC  1: mtval = faulting PC on EBREAK, 0: mtval = 0
module trap_controller #(
    parameter int XLEN           = 32,
    parameter bit EBREAK_TVAL_PC = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    trap_controller_if.master     bus
);
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam logic [2:0] KIND_ECALL    = 3'd0;
    localparam logic [2:0] KIND_EBREAK   = 3'd1;
    localparam logic [2:0] KIND_MRET     = 3'd6;
    localparam logic [2:0] KIND_RESERVED = 3'd7;

    typedef enum logic [2:0] {
        IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, R_VEC, REDIRECT
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] tval_q;
    logic [2:0]      kind_q;
    logic            is_mret;
    logic            accept;
    logic [3:0]      cause_code;
    logic [XLEN-1:0] mstatus_next;
    logic [XLEN-1:0] mtval_value;

    assign is_mret = (kind_q == KIND_MRET);
    // Reserved kind is dropped entirely, so it must not stall the PC either.
    assign accept  = bus.trap_valid && (bus.trap_kind != KIND_RESERVED);

    assign bus.trap_done = !reset_n || ((state == IDLE) && !accept) || (state == REDIRECT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            pc_q              <= '0;
            tval_q            <= '0;
            kind_q            <= '0;
            bus.trap_redirect <= 1'b0;
            bus.trap_target   <= '0;
        end else begin
            bus.trap_redirect <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        pc_q   <= bus.trap_pc;
                        tval_q <= bus.trap_tval;
                        kind_q <= bus.trap_kind;
                        state  <= (bus.trap_kind == KIND_MRET) ? W_MSTATUS : W_MEPC;
                    end
                end
                W_MEPC:    if (bus.csr_ready) state <= W_MCAUSE;
                W_MCAUSE:  if (bus.csr_ready) state <= W_MTVAL;
                W_MTVAL:   if (bus.csr_ready) state <= W_MSTATUS;
                W_MSTATUS: if (bus.csr_ready) state <= R_VEC;
                R_VEC: begin
                    // mtvec MODE bits are dropped: synchronous exceptions always use BASE.
                    bus.trap_target   <= {bus.csr_trap_read_data[XLEN-1:2], 2'b00};
                    bus.trap_redirect <= 1'b1;
                    state             <= REDIRECT;
                end
                REDIRECT:  state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    always_comb begin
        cause_code = 4'd0;
        case (kind_q)
            3'd0:    cause_code = 4'd11;
            3'd1:    cause_code = 4'd3;
            3'd2:    cause_code = 4'd0;
            3'd3:    cause_code = 4'd4;
            3'd4:    cause_code = 4'd6;
            3'd5:    cause_code = 4'd2;
            default: cause_code = 4'd0;
        endcase
    end

    always_comb begin
        mtval_value = tval_q;
        if (kind_q == KIND_ECALL) begin
            mtval_value = '0;
        end else if (kind_q == KIND_EBREAK) begin
            mtval_value = EBREAK_TVAL_PC ? pc_q : '0;
        end
    end

    // mstatus read-modify-write happens within the W_MSTATUS cycle on the combinational read data.
    always_comb begin
        mstatus_next = bus.csr_trap_read_data;
        if (is_mret) begin
            mstatus_next[3] = bus.csr_trap_read_data[7];
            mstatus_next[7] = 1'b1;
        end else begin
            mstatus_next[7] = bus.csr_trap_read_data[3];
            mstatus_next[3] = 1'b0;
        end
        mstatus_next[12:11] = 2'b11;
    end

    always_comb begin
        bus.csr_trap_write         = 1'b0;
        bus.csr_trap_write_address = '0;
        bus.csr_trap_write_data    = '0;
        bus.csr_trap_read_address  = '0;
        case (state)
            W_MEPC: begin
                bus.csr_trap_write         = 1'b1;
                bus.csr_trap_write_address = CSR_MEPC;
                bus.csr_trap_write_data    = {pc_q[XLEN-1:2], 2'b00};
            end
            W_MCAUSE: begin
                bus.csr_trap_write         = 1'b1;
                bus.csr_trap_write_address = CSR_MCAUSE;
                bus.csr_trap_write_data    = XLEN'(cause_code);
            end
            W_MTVAL: begin
                bus.csr_trap_write         = 1'b1;
                bus.csr_trap_write_address = CSR_MTVAL;
                bus.csr_trap_write_data    = mtval_value;
            end
            W_MSTATUS: begin
                bus.csr_trap_write         = 1'b1;
                bus.csr_trap_read_address  = CSR_MSTATUS;
                bus.csr_trap_write_address = CSR_MSTATUS;
                bus.csr_trap_write_data    = mstatus_next;
            end
            R_VEC: begin
                bus.csr_trap_read_address  = is_mret ? CSR_MEPC : CSR_MTVEC;
            end
            default: begin
            end
        endcase
    end
endmodule
